xconverter_upsize: RTL and testbench
====================================

// Module: xconverter_upsize
// PURPOSE
//   Narrow-to-wide beat packer for the DMA read-return path; inverse of the downsize converter.
//   Collects DWIDTH_S-wide beats into one DWIDTH_D-wide word with per-byte strobes, then presents it downstream.
//   Lane placement follows the beat address, so an unaligned first beat lands in its correct lane.
//   Sits between the narrow slave-side return data and the wide DMA buffer write port.
// PARAMETERS
//   DWIDTH_S  32   narrow input data width (bits)
//   DWIDTH_D  256  wide output data width (bits); DWIDTH_D/DWIDTH_S = DWM, power of 2, >=2
//   DWADDR    32   byte address width
// PORTS
//   xclk     in   1             clock, all logic on rising edge
//   xreset   in   1             synchronous reset, active-high
//   s_valid  in   1             narrow beat valid
//   s_ready  out  1             narrow beat accepted when s_valid & s_ready
//   s_data   in   DWIDTH_S      narrow beat data
//   s_addr   in   DWADDR        byte address of beat
//   s_strb   in   DWIDTH_S/8    byte strobes of beat
//   s_last   in   1             final beat of burst; forces word close
//   m_valid  out  1             wide word valid
//   m_ready  in   1             wide word taken when m_valid & m_ready
//   m_data   out  DWIDTH_D      packed word
//   m_addr   out  DWADDR        word address, aligned to DWIDTH_D/8 bytes
//   m_strb   out  DWIDTH_D/8    byte strobes of packed word
//   m_last   out  1             word contains the s_last beat
// BEHAVIOUR
//   - CWIDTH=log2(DWM), LSB=log2(DWIDTH_S/8). Lane of first beat of a word = s_addr[LSB +: CWIDTH]; later beats lane+1.
//   - Pack-register states: EMPTY -> FILLING (first beat accepted, not closing) -> FULL (closing beat accepted).
//     EMPTY -> FULL directly if first beat closes. FULL -> EMPTY on transfer; FULL -> FILLING/FULL on transfer + same-cycle beat.
//   - A beat closes the word when its lane == DWM-1 or s_last=1.
//   - Accepted beat writes s_data/s_strb into its lane; other lanes keep their value.
//   - out_free = ~m_valid | m_ready. Transfer pack->output regs when FULL & out_free, same edge.
//   - s_ready = (state!=FULL) | out_free (no dependence on s_valid). Transfer + new beat in same cycle allowed: full throughput.
//   - Latency: closing beat accepted at edge N -> FULL; m_valid=1 after edge N+1 if out_free at N+1.
//   - m_addr = first-beat s_addr with low log2(DWIDTH_D/8) bits cleared. m_last = s_last of closing beat.
//   - Strobes of lanes not written in a word are 0. Pack strobes cleared on transfer.
//   - m_* held stable while m_valid & ~m_ready.
//   - Address discontinuity inside a word is not detected; upstream guarantees sequential beats.
//   - Reset: m_valid=0, m_data=0, m_addr=0, m_strb=0, m_last=0, state=EMPTY, lane=0; s_ready=1 after reset.
//     Reset mid-word discards partial word and any held output word; no output produced.
// CONFIGURATION
//   XCONV_UPSIZE_ZERO_FILL_EN defined: on transfer, lanes of pack data reg are cleared to 0,
//     so unwritten lanes of m_data read 0.
//   Not defined: pack data reg not cleared; unwritten lanes carry stale data (strobe still 0). Saves DWIDTH_D reset muxes.
// STRUCTURE
//   Package xconv_pkg: state enum {EMPTY,FILLING,FULL}, lane-index width function clog2-based, LSB constant helper.
//   Sub-module xconv_lane_demux: binary lane index -> DWM one-hot write enable, gated by accept.
// TESTING (DWIDTH_S=32, DWIDTH_D=256, DWADDR=32)
//   1 Aligned burst: 8 beats addr 0x100..0x11C, data 0..7, strb 0xF, last on 8th, m_ready=1
//     -> one word m_data={32'h7,...,32'h0}, m_strb=32'hFFFFFFFF, m_addr=0x100, m_last=1.
//   2 Unaligned short: 3 beats addr 0x108,0x10C,0x110, last on 3rd -> m_strb=32'h000FFF00, m_addr=0x100, m_last=1.
//   3 Backpressure: m_ready=0, 16 aligned beats -> s_ready=0 after beat 16 accepted;
//     raise m_ready -> two words in order, addr 0x100 then 0x120, no beat lost.
//   4 Throughput: m_ready=1, s_valid=1, 64 beats -> 8 words, s_ready never deasserted, one word per 8 cycles.
//   5 Reset mid-word: 3 beats accepted then xreset 1 cycle -> no m_valid; next 8-beat burst yields clean word, strb all-ones.
//   6 Zero-fill: test 2 with XCONV_UPSIZE_ZERO_FILL_EN after a prior full word of 0xFFFFFFFF
//     -> lanes 0,1,5..7 of m_data = 0; without macro -> those lanes = 0xFFFFFFFF, m_strb unchanged.

Source files
------------

// File: rtl/xconv_pkg.sv
// Shared types and width helpers for the narrow-to-wide beat packer.
package xconv_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } pack_state_t;

    // Width of a lane index for a word holding dwm narrow beats.
    function automatic int lane_width(input int dwm);
        return (dwm > 1) ? $clog2(dwm) : 1;
    endfunction

    // Bit position in a byte address where the narrow-beat lane index starts.
    function automatic int lsb_index(input int dwidth_s);
        return $clog2(dwidth_s / 8);
    endfunction

endpackage

// File: rtl/xconv_lane_demux.sv
// Turns a binary lane index into a one-hot lane write enable, active only on an accepted beat.
module xconv_lane_demux
    import xconv_pkg::*;
#(
    parameter int DWM    = 8,
    parameter int CWIDTH = lane_width(DWM)
) (
    input  logic [CWIDTH-1:0] lane,
    input  logic              accept,
    output logic [DWM-1:0]    lane_we
);

    always_comb begin
        lane_we = '0;
        for (int i = 0; i < DWM; i++) begin
            if (accept && (lane == CWIDTH'(i))) begin
                lane_we[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/xconverter_upsize.sv
// Narrow-to-wide beat packer for the DMA read-return path.
// Define XCONV_UPSIZE_ZERO_FILL_EN to clear the pack data register on each transfer.
module xconverter_upsize
    import xconv_pkg::*;
#(
    parameter int DWIDTH_S = 32,
    parameter int DWIDTH_D = 256,
    parameter int DWADDR   = 32
) (
    input  logic                    xclk,
    input  logic                    xreset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DWIDTH_S-1:0]     s_data,
    input  logic [DWADDR-1:0]       s_addr,
    input  logic [DWIDTH_S/8-1:0]   s_strb,
    input  logic                    s_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [DWIDTH_D-1:0]     m_data,
    output logic [DWADDR-1:0]       m_addr,
    output logic [DWIDTH_D/8-1:0]   m_strb,
    output logic                    m_last
);

    localparam int DWM    = DWIDTH_D / DWIDTH_S;
    localparam int CWIDTH = lane_width(DWM);
    localparam int LSB    = lsb_index(DWIDTH_S);
    localparam int SB     = DWIDTH_S / 8;
    localparam int DB     = DWIDTH_D / 8;
    localparam logic [DWADDR-1:0] WORD_MASK = ~DWADDR'(DB - 1);

    pack_state_t         state_q;
    pack_state_t         state_d;
    logic [CWIDTH-1:0]   lane_q;
    logic [CWIDTH-1:0]   beat_lane;
    logic [DWM-1:0]      lane_we;
    logic [DWIDTH_D-1:0] pack_data;
    logic [DB-1:0]       pack_strb;
    logic [DWADDR-1:0]   pack_addr;
    logic                pack_last;
    logic                out_free;
    logic                transfer;
    logic                accept;
    logic                first_beat;
    logic                closing;

    assign out_free   = ~m_valid | m_ready;
    assign transfer   = (state_q == FULL) & out_free;
    assign s_ready    = (state_q != FULL) | out_free;
    assign accept     = s_valid & s_ready;
    // Any beat that is not continuing a partial word starts a new one and takes its lane from the address.
    assign first_beat = (state_q != FILLING);
    assign beat_lane  = first_beat ? s_addr[LSB +: CWIDTH] : lane_q;
    assign closing    = (beat_lane == {CWIDTH{1'b1}}) | s_last;

    xconv_lane_demux #(
        .DWM    (DWM),
        .CWIDTH (CWIDTH)
    ) u_lane_demux (
        .lane    (beat_lane),
        .accept  (accept),
        .lane_we (lane_we)
    );

    always_ff @(posedge xclk) begin
        if (xreset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY, FILLING: begin
                if (accept) state_d = closing ? FULL : FILLING;
            end
            FULL: begin
                if (transfer) state_d = accept ? (closing ? FULL : FILLING) : EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Lane writes land after the transfer clear so a same-cycle first beat survives.
    always_ff @(posedge xclk) begin
        if (xreset) begin
            pack_strb <= '0;
            pack_addr <= '0;
            pack_last <= 1'b0;
            lane_q    <= '0;
        end else begin
            if (transfer) pack_strb <= '0;
            for (int i = 0; i < DWM; i++) begin
                if (lane_we[i]) pack_strb[i*SB +: SB] <= s_strb;
            end
            if (accept) begin
                lane_q <= beat_lane + 1'b1;
                if (first_beat) pack_addr <= s_addr & WORD_MASK;
                if (closing)    pack_last <= s_last;
            end
        end
    end

    always_ff @(posedge xclk) begin
`ifdef XCONV_UPSIZE_ZERO_FILL_EN
        if (xreset || transfer) pack_data <= '0;
`endif
        for (int i = 0; i < DWM; i++) begin
            if (lane_we[i] && !xreset) pack_data[i*DWIDTH_S +: DWIDTH_S] <= s_data;
        end
    end

    always_ff @(posedge xclk) begin
        if (xreset) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_addr  <= '0;
            m_strb  <= '0;
            m_last  <= 1'b0;
        end else if (transfer) begin
            m_valid <= 1'b1;
            m_data  <= pack_data;
            m_addr  <= pack_addr;
            m_strb  <= pack_strb;
            m_last  <= pack_last;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xconverter_upsize.sv
// Self-checking bench for xconverter_upsize: random beats checked against a beat-to-word packing model.
module tb_xconverter_upsize;

    logic         xclk;
    logic         xreset;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic [31:0]  s_addr;
    logic [3:0]   s_strb;
    logic         s_last;
    logic         m_valid;
    logic         m_ready;
    logic [255:0] m_data;
    logic [31:0]  m_addr;
    logic [31:0]  m_strb;
    logic         m_last;

    int errors = 0;
    int checks = 0;

    xconverter_upsize #(
        .DWIDTH_S (32),
        .DWIDTH_D (256),
        .DWADDR   (32)
    ) dut (
        .xclk    (xclk),
        .xreset  (xreset),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_addr  (s_addr),
        .s_strb  (s_strb),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_addr  (m_addr),
        .m_strb  (m_strb),
        .m_last  (m_last)
    );

    initial xclk = 1'b0;
    always #5 xclk = ~xclk;

    typedef struct {
        logic [255:0] data;
        logic [255:0] known;
        logic [31:0]  addr;
        logic [31:0]  strb;
        logic         last;
        int           t;
    } word_t;

    word_t exp_q[$];
    word_t got_q[$];

    // Reference model: beats group into words; lane contents persist between words unless zero-filled.
    logic [31:0] lane_val [8];
    bit          lane_known [8];
    bit          m_open = 0;
    int          m_lane = 0;
    logic [31:0] cur_addr;
    logic [31:0] cur_strb;

    int          cycle = 0;
    int          stall_cnt = 0;
    int          hold_err = 0;
    bit          hold_prev = 0;
    bit          rand_ready = 0;
    logic [255:0] prev_data;
    logic [31:0]  prev_addr;
    logic [31:0]  prev_strb;
    logic         prev_last;

    task automatic model_reset();
        m_open = 0;
        for (int i = 0; i < 8; i++) lane_known[i] = 0;
        exp_q.delete();
        got_q.delete();
        hold_prev = 0;
    endtask

    task automatic model_beat(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] st, input logic l);
        word_t w;
        if (!m_open) begin
            m_open   = 1;
            m_lane   = int'(a[4:2]);
            cur_addr = a & ~32'h1F;
            cur_strb = '0;
        end
        lane_val[m_lane]   = d;
        lane_known[m_lane] = 1;
        cur_strb[m_lane*4 +: 4] = st;
        if (m_lane == 7 || l) begin
            for (int i = 0; i < 8; i++) begin
                w.data[i*32 +: 32]  = lane_val[i];
                w.known[i*32 +: 32] = lane_known[i] ? 32'hFFFF_FFFF : 32'h0;
            end
            w.addr = cur_addr;
            w.strb = cur_strb;
            w.last = l;
            w.t    = 0;
            exp_q.push_back(w);
            m_open = 0;
`ifdef XCONV_UPSIZE_ZERO_FILL_EN
            for (int i = 0; i < 8; i++) begin
                lane_val[i]   = 32'h0;
                lane_known[i] = 1;
            end
`endif
        end else begin
            m_lane++;
        end
    endtask

    // One clock: observe handshakes before the edge, then advance past it.
    task automatic step(output bit accepted);
        word_t g;
        if (rand_ready) m_ready = 1'($urandom_range(0, 1));
        @(negedge xclk);
        accepted = s_valid && s_ready;
        if (hold_prev && (m_valid !== 1'b1 || m_data !== prev_data || m_addr !== prev_addr ||
                          m_strb !== prev_strb || m_last !== prev_last)) hold_err++;
        hold_prev = m_valid && !m_ready;
        prev_data = m_data;
        prev_addr = m_addr;
        prev_strb = m_strb;
        prev_last = m_last;
        if (m_valid && m_ready) begin
            g.data  = m_data;
            g.known = '1;
            g.addr  = m_addr;
            g.strb  = m_strb;
            g.last  = m_last;
            g.t     = cycle;
            got_q.push_back(g);
        end
        if (s_valid && !s_ready) stall_cnt++;
        if (accepted) model_beat(s_addr, s_data, s_strb, s_last);
        @(posedge xclk);
        #1;
        cycle++;
    endtask

    task automatic idle(input int n);
        bit acc;
        s_valid = 0;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    task automatic send_beat(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] st, input logic l);
        bit acc;
        int n = 0;
        s_valid = 1;
        s_addr  = a;
        s_data  = d;
        s_strb  = st;
        s_last  = l;
        do begin
            step(acc);
            n++;
        end while (!acc && n < 200);
        s_valid = 0;
        checks++;
        if (!acc) begin
            errors++;
            $display("[TB] FAIL beat_accept addr=%h got no handshake in %0d cycles, required acceptance", a, n);
        end
    endtask

    task automatic drain();
        int n = 0;
        bit acc;
        s_valid = 0;
        while (got_q.size() < exp_q.size() && n < 500) begin
            step(acc);
            n++;
        end
        idle(3);
    endtask

    task automatic do_reset();
        s_valid = 0;
        xreset  = 1;
        @(posedge xclk);
        #1;
        xreset = 0;
        model_reset();
    endtask

    task automatic test_reset();
        xreset  = 1;
        s_valid = 0;
        m_ready = 1;
        s_addr  = '0;
        s_data  = '0;
        s_strb  = '0;
        s_last  = 0;
        repeat (3) @(posedge xclk);
        #1;
        xreset = 0;
        model_reset();
        checks += 6;
        if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid got %b required 0", m_valid); end
        if (m_data !== '0) begin errors++; $display("[TB] FAIL reset_m_data got %h required 0", m_data); end
        if (m_addr !== '0) begin errors++; $display("[TB] FAIL reset_m_addr got %h required 0", m_addr); end
        if (m_strb !== '0) begin errors++; $display("[TB] FAIL reset_m_strb got %h required 0", m_strb); end
        if (m_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_last got %b required 0", m_last); end
        if (s_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_s_ready got %b required 1", s_ready); end
    endtask

    task automatic test_aligned();
        logic [255:0] want;
        for (int i = 0; i < 8; i++) want[i*32 +: 32] = i;
        m_ready = 1;
        for (int i = 0; i < 8; i++) send_beat(32'h100 + 4*i, i, 4'hF, i == 7);
        drain();
        checks++;
        if (got_q.size() !== 1) begin
            errors++;
            $display("[TB] FAIL aligned_count got %0d words required 1", got_q.size());
        end else begin
            checks += 4;
            if (got_q[0].data !== want) begin errors++; $display("[TB] FAIL aligned_data got %h required %h", got_q[0].data, want); end
            if (got_q[0].strb !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL aligned_strb got %h required ffffffff", got_q[0].strb); end
            if (got_q[0].addr !== 32'h100) begin errors++; $display("[TB] FAIL aligned_addr got %h required 00000100", got_q[0].addr); end
            if (got_q[0].last !== 1'b1) begin errors++; $display("[TB] FAIL aligned_last got %b required 1", got_q[0].last); end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    // Short unaligned word after an all-ones word exposes what unwritten lanes carry.
    task automatic test_zero_fill();
        logic [31:0] d [3];
        logic [31:0] fill;
`ifdef XCONV_UPSIZE_ZERO_FILL_EN
        fill = 32'h0;
`else
        fill = 32'hFFFF_FFFF;
`endif
        m_ready = 1;
        for (int i = 0; i < 8; i++) send_beat(32'h100 + 4*i, 32'hFFFF_FFFF, 4'hF, i == 7);
        drain();
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < 3; i++) begin
            d[i] = $urandom;
            send_beat(32'h108 + 4*i, d[i], 4'hF, i == 2);
        end
        drain();
        checks++;
        if (got_q.size() !== 1) begin
            errors++;
            $display("[TB] FAIL unaligned_count got %0d words required 1", got_q.size());
        end else begin
            checks += 4;
            if (got_q[0].strb !== 32'h000F_FF00) begin errors++; $display("[TB] FAIL unaligned_strb got %h required 000fff00", got_q[0].strb); end
            if (got_q[0].addr !== 32'h100) begin errors++; $display("[TB] FAIL unaligned_addr got %h required 00000100", got_q[0].addr); end
            if (got_q[0].last !== 1'b1) begin errors++; $display("[TB] FAIL unaligned_last got %b required 1", got_q[0].last); end
            if (got_q[0].data[159:64] !== {d[2], d[1], d[0]}) begin
                errors++;
                $display("[TB] FAIL unaligned_lanes got %h required %h", got_q[0].data[159:64], {d[2], d[1], d[0]});
            end
            for (int l = 0; l < 8; l++) begin
                if (l >= 2 && l <= 4) continue;
                checks++;
                if (got_q[0].data[l*32 +: 32] !== fill) begin
                    errors++;
                    $display("[TB] FAIL unwritten_lane%0d got %h required %h", l, got_q[0].data[l*32 +: 32], fill);
                end
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_backpressure();
        m_ready   = 0;
        stall_cnt = 0;
        hold_err  = 0;
        for (int i = 0; i < 16; i++) send_beat(32'h100 + 4*i, $urandom, 4'hF, i == 15);
        checks += 2;
        if (s_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_s_ready got %b required 0", s_ready); end
        if (stall_cnt !== 0) begin errors++; $display("[TB] FAIL bp_stalls got %0d required 0", stall_cnt); end
        idle(5);
        m_ready = 1;
        drain();
        checks += 4;
        if (hold_err !== 0) begin errors++; $display("[TB] FAIL bp_hold got %0d changes required 0", hold_err); end
        if (got_q.size() !== 2 || exp_q.size() !== 2) begin
            errors++;
            $display("[TB] FAIL bp_count got %0d words required 2", got_q.size());
        end else begin
            if (got_q[0].addr !== 32'h100 || got_q[1].addr !== 32'h120) begin
                errors++;
                $display("[TB] FAIL bp_order got %h,%h required 00000100,00000120", got_q[0].addr, got_q[1].addr);
            end
            if (got_q[0].data !== exp_q[0].data || got_q[1].data !== exp_q[1].data) begin
                errors++;
                $display("[TB] FAIL bp_data got %h required %h", got_q[1].data, exp_q[1].data);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_throughput();
        m_ready   = 1;
        stall_cnt = 0;
        for (int i = 0; i < 64; i++) send_beat(32'h2000 + 4*i, $urandom, 4'($urandom), i == 63);
        drain();
        checks += 2;
        if (stall_cnt !== 0) begin errors++; $display("[TB] FAIL tput_stalls got %0d required 0", stall_cnt); end
        if (got_q.size() !== 8 || exp_q.size() !== 8) begin
            errors++;
            $display("[TB] FAIL tput_count got %0d words required 8", got_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (((got_q[i].data ^ exp_q[i].data) & exp_q[i].known) !== '0 || got_q[i].addr !== exp_q[i].addr ||
                    got_q[i].strb !== exp_q[i].strb || got_q[i].last !== exp_q[i].last) begin
                    errors++;
                    $display("[TB] FAIL tput_word%0d got addr=%h strb=%h last=%b data=%h required addr=%h strb=%h last=%b data=%h",
                             i, got_q[i].addr, got_q[i].strb, got_q[i].last, got_q[i].data,
                             exp_q[i].addr, exp_q[i].strb, exp_q[i].last, exp_q[i].data);
                end
                if (i > 0) begin
                    checks++;
                    if (got_q[i].t - got_q[i-1].t !== 8) begin
                        errors++;
                        $display("[TB] FAIL tput_spacing%0d got %0d cycles required 8", i, got_q[i].t - got_q[i-1].t);
                    end
                end
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset_midword();
        m_ready = 1;
        for (int i = 0; i < 3; i++) send_beat(32'h200 + 4*i, $urandom, 4'hF, 1'b0);
        do_reset();
        idle(12);
        checks++;
        if (got_q.size() !== 0) begin errors++; $display("[TB] FAIL rst_no_output got %0d words required 0", got_q.size()); end
        for (int i = 0; i < 8; i++) send_beat(32'h300 + 4*i, $urandom, 4'hF, i == 7);
        drain();
        checks++;
        if (got_q.size() !== 1 || exp_q.size() !== 1) begin
            errors++;
            $display("[TB] FAIL rst_count got %0d words required 1", got_q.size());
        end else begin
            checks += 2;
            if (got_q[0].strb !== 32'hFFFF_FFFF || got_q[0].addr !== 32'h300) begin
                errors++;
                $display("[TB] FAIL rst_word got strb=%h addr=%h required ffffffff 00000300", got_q[0].strb, got_q[0].addr);
            end
            if (got_q[0].data !== exp_q[0].data) begin
                errors++;
                $display("[TB] FAIL rst_data got %h required %h", got_q[0].data, exp_q[0].data);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_random();
        bit acc;
        logic [31:0] a;
        int len;
        hold_err   = 0;
        rand_ready = 1;
        for (int b = 0; b < 12; b++) begin
            a   = 32'h1000 + {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) step(acc);
                send_beat(a + 4*i, $urandom, 4'($urandom), i == len - 1);
            end
        end
        rand_ready = 0;
        m_ready    = 1;
        drain();
        checks += 2;
        if (hold_err !== 0) begin errors++; $display("[TB] FAIL rand_hold got %0d changes required 0", hold_err); end
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("[TB] FAIL rand_count got %0d words required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (((got_q[i].data ^ exp_q[i].data) & exp_q[i].known) !== '0 || got_q[i].addr !== exp_q[i].addr ||
                got_q[i].strb !== exp_q[i].strb || got_q[i].last !== exp_q[i].last) begin
                errors++;
                $display("[TB] FAIL rand_word%0d got addr=%h strb=%h last=%b data=%h required addr=%h strb=%h last=%b data=%h",
                         i, got_q[i].addr, got_q[i].strb, got_q[i].last, got_q[i].data,
                         exp_q[i].addr, exp_q[i].strb, exp_q[i].last, exp_q[i].data);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_zero_fill();
        test_backpressure();
        test_throughput();
        test_reset_midword();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
